// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: issue/collect front end for a V-lane x N-bit vector ALU.
// Accepts one operation over in_valid/in_ready, drives registered operands and
// opcode to the ALU, waits the opcode's settle time, registers lane results and
// flags, and presents them downstream over out_valid/out_ready.
// Optional feature: define VEC_ALU_SEQ_BYPASS_EN to let a new operation be
// accepted on the same edge that completes the result handshake.
module vec_alu_sequencer #(
  parameter int N       = 18,
  parameter int V       = 3,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [V*N-1:0]     in_a,
  input  logic [V*N-1:0]     in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [V*N-1:0]     alu_a,
  output logic [V*N-1:0]     alu_b,
  output logic [2:0]         alu_c,
  input  logic [V*N-1:0]     alu_r,
  input  logic [3:0]         alu_f,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [V*N-1:0]     out_r,
  output logic [3:0]         out_f,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] MUL_CNT = 3'(MUL_LAT);

  state_e             state_q;
  logic [2:0]         cnt_q;
  logic [TAG_W-1:0]   tag_q;
  logic               accept;
  logic               illegal_op;

`ifdef VEC_ALU_SEQ_BYPASS_EN
  // Ready in IDLE, or in HOLD when the pending result drains on this edge.
  assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
`else
  // Ready only in IDLE.
  assign in_ready = (state_q == IDLE);
`endif

  assign accept     = in_valid & in_ready;
  assign busy       = (state_q != IDLE);
  assign illegal_op = (alu_c[2:1] == 2'b11);

  // Issue/collect FSM with all datapath registers it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, including the wide operand/result registers,
    // is reset so that a reset mid-operation leaves nothing half-presented.
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tag_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_c     <= OP_ADD;
      out_r     <= '0;
      out_f     <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a   <= in_a;
            alu_b   <= in_b;
            alu_c   <= in_op;
            tag_q   <= in_tag;
            cnt_q   <= (in_op == OP_MUL) ? MUL_CNT : 3'd0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            out_r     <= illegal_op ? '0 : alu_r;
            out_f     <= illegal_op ? 4'b0100 : alu_f;
            out_tag   <= tag_q;
            out_err   <= illegal_op;
            out_valid <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              // Only reachable with the bypass feature enabled.
              alu_a   <= in_a;
              alu_b   <= in_b;
              alu_c   <= in_op;
              tag_q   <= in_tag;
              cnt_q   <= (in_op == OP_MUL) ? MUL_CNT : 3'd0;
              state_q <= EXEC;
            end else begin
              // Park the opcode decode; operands keep their values.
              alu_c   <= OP_ADD;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
